id_code_rx: RTL and testbench

ID_CODE_RX -- requirements
Module: id_code_rx

---
 rtl/id_code_pkg.sv | 47 ++++
 rtl/id_code_rx_fifo.sv | 73 +++++++
 rtl/id_code_rx.sv | 98 +++++++++
 tb/tb_id_code_rx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_code_pkg.sv
// Shared constants for the ID code link: code width, the encoder's
// source-ID -> code table and the receiver's code -> canonical-ID table.
// Code map (source IDs sharing a code decode to the lowest of them):
//   id 0 -> 0x1, ids 1-2 -> 0x3, ids 3-6 -> 0x7, ids 7-8 -> 0xF,
//   ids 9-10 -> 0x0, ids 11-15 -> 0x5. Every other code is illegal.
package id_code_pkg;

    localparam int CODE_W = 4;
    localparam int IDX_W  = 4;

    // Bit n set means code n can be produced by the encoder.
    localparam logic [15:0] CODE_LEGAL_MASK = 16'h80AB;

    // Encoder table: source ID to transmitted code.
    function automatic logic [CODE_W-1:0] id_encode(input logic [IDX_W-1:0] id);
        logic [CODE_W-1:0] code;
        case (id)
            4'h0:                   code = 4'h1;
            4'h1, 4'h2:             code = 4'h3;
            4'h3, 4'h4, 4'h5, 4'h6: code = 4'h7;
            4'h7, 4'h8:             code = 4'hF;
            4'h9, 4'hA:             code = 4'h0;
            default:                code = 4'h5;
        endcase
        return code;
    endfunction

    function automatic logic code_is_legal(input logic [CODE_W-1:0] code);
        return CODE_LEGAL_MASK[code];
    endfunction

    // Receiver table: legal code to the lowest source ID that produces it.
    function automatic logic [IDX_W-1:0] code_decode(input logic [CODE_W-1:0] code);
        logic [IDX_W-1:0] idx;
        case (code)
            4'h1:    idx = 4'h0;
            4'h3:    idx = 4'h1;
            4'h7:    idx = 4'h3;
            4'hF:    idx = 4'h7;
            4'h0:    idx = 4'h9;
            4'h5:    idx = 4'hB;
            default: idx = 4'h0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/id_code_rx_fifo.sv
// Synchronous FIFO holding decoded indices. Pushes are ignored when full and
// pops are ignored when empty, so a full FIFO never takes a same-cycle push
// even if it is also being popped. dout_o reads 0 while empty.
module id_code_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == DEPTH_CNT);
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards all buffered entries.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write; contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/id_code_rx.sv
// ID code receiver: accepts encoded IDs, drops illegal codes, decodes legal
// ones to the canonical (lowest) source ID and buffers them in a FIFO.
// Illegal-code reporting (id_err pulse, saturating err_cnt, err_clr) is built
// only when ID_CODE_RX_ERR_EN is defined; otherwise those outputs are 0.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Input side: id_ok & id_code_vld & id_code_rdy accepts a code
// (id_code_rdy does not depend on id_code_vld). Output side:
// idx_vld & idx_rdy pops; idx_out holds while idx_vld & ~idx_rdy.
module id_code_rx
    import id_code_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              id_ok,
    input  logic [CODE_W-1:0] id_code,
    input  logic              id_code_vld,
    output logic              id_code_rdy,
    output logic [IDX_W-1:0]  idx_out,
    output logic              idx_vld,
    input  logic              idx_rdy,
    input  logic              err_clr,
    output logic              id_err,
    output logic [CNT_W-1:0]  err_cnt
);

    logic             fifo_full;
    logic             fifo_empty;
    logic             accept;
    logic             code_legal;
    logic             push;
    logic [IDX_W-1:0] decoded_idx;

    assign code_legal  = code_is_legal(id_code);
    assign decoded_idx = code_decode(id_code);
    assign accept      = id_ok & id_code_vld & ~fifo_full;
    assign push        = accept & code_legal;

    assign id_code_rdy = ~fifo_full;
    assign idx_vld     = ~fifo_empty;

    id_code_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (IDX_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (push),
        .pop_i   (idx_rdy),
        .din_i   (decoded_idx),
        .dout_o  (idx_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef ID_CODE_RX_ERR_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             illegal_acc;
    logic             id_err_q;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    assign illegal_acc = accept & ~code_legal;

    // Next error count: clear wins, else saturating increment per dropped code.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (illegal_acc && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    // Error pulse lags the accepted illegal code by one cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            id_err_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            id_err_q  <= illegal_acc;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign id_err  = id_err_q;
    assign err_cnt = err_cnt_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign id_err         = 1'b0;
    assign err_cnt        = '0;
`endif

endmodule

// File: tb/tb_id_code_rx.sv
// Bench for id_code_rx: directed vectors, a queue-based reference model
// updated on each rising edge, a per-cycle compare on the falling edge, and
// hand-computed literal checks at key points of each scenario.
module tb_id_code_rx;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef ID_CODE_RX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic             id_ok;
    logic [3:0]       id_code;
    logic             id_code_vld;
    logic             id_code_rdy;
    logic [3:0]       idx_out;
    logic             idx_vld;
    logic             idx_rdy;
    logic             err_clr;
    logic             id_err;
    logic [CNT_W-1:0] err_cnt;

    id_code_rx #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .id_ok       (id_ok),
        .id_code     (id_code),
        .id_code_vld (id_code_vld),
        .id_code_rdy (id_code_rdy),
        .idx_out     (idx_out),
        .idx_vld     (idx_vld),
        .idx_rdy     (idx_rdy),
        .err_clr     (err_clr),
        .id_err      (id_err),
        .err_cnt     (err_cnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Decode table straight from the code map; -1 marks an illegal code.
    int         dec_tbl [16];
    logic [3:0] exp_q [$];
    bit         m_err;
    int         m_cnt;
    bit         m_acc;
    bit         m_pop;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exp_q.delete();
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            m_pop = (exp_q.size() > 0) && (idx_rdy === 1'b1);
            m_acc = (id_ok === 1'b1) && (id_code_vld === 1'b1) && (exp_q.size() < DEPTH);
            m_err = 1'b0;
            if (m_pop) begin
                exp_q.delete(0);
            end
            if (m_acc) begin
                if (dec_tbl[id_code] >= 0) begin
                    exp_q.push_back(4'(dec_tbl[id_code]));
                end else if (ERR_EN) begin
                    m_err = 1'b1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
            end
            if (ERR_EN && (err_clr === 1'b1)) begin
                m_cnt = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            chk("idx_vld", 32'(idx_vld), 32'(exp_q.size() > 0));
            chk("idx_out", 32'(idx_out), (exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
            chk("id_code_rdy", 32'(id_code_rdy), 32'(exp_q.size() < DEPTH));
            chk("id_err", 32'(id_err), 32'(m_err));
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a code for one edge and leave id_code_vld high (back-to-back use).
    task automatic send_keep(input logic [3:0] c);
        id_code     = c;
        id_code_vld = 1'b1;
        tick();
    endtask

    task automatic send(input logic [3:0] c);
        send_keep(c);
        id_code_vld = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 16; i++) dec_tbl[i] = -1;
        dec_tbl[4'h1] = 4'h0;
        dec_tbl[4'h3] = 4'h1;
        dec_tbl[4'h7] = 4'h3;
        dec_tbl[4'hF] = 4'h7;
        dec_tbl[4'h0] = 4'h9;
        dec_tbl[4'h5] = 4'hB;

        resetn      = 1'b0;
        id_ok       = 1'b0;
        id_code     = 4'h0;
        id_code_vld = 1'b0;
        idx_rdy     = 1'b0;
        err_clr     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_idx_vld", 32'(idx_vld), 32'd0);
        chk("rst_idx_out", 32'(idx_out), 32'd0);
        chk("rst_rdy", 32'(id_code_rdy), 32'd1);
        chk("rst_id_err", 32'(id_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_rdy", 32'(id_code_rdy), 32'd1);
        chk("post_rst_vld", 32'(idx_vld), 32'd0);

        // Single code 0x7 -> index 0x3 one cycle later, then empty
        id_ok   = 1'b1;
        idx_rdy = 1'b1;
        send(4'h7);
        @(negedge clk);
        chk("single_vld", 32'(idx_vld), 32'd1);
        chk("single_out", 32'(idx_out), 32'h3);
        @(negedge clk);
        chk("single_vld_after", 32'(idx_vld), 32'd0);

        // Back-to-back fill, 5th refused, drain in order
        idx_rdy = 1'b0;
        send_keep(4'h1);
        send_keep(4'h3);
        send_keep(4'hF);
        send_keep(4'h0);
        send_keep(4'h5);
        id_code_vld = 1'b0;
        @(negedge clk);
        chk("fill_rdy", 32'(id_code_rdy), 32'd0);
        chk("drain0", 32'(idx_out), 32'h0);
        idx_rdy = 1'b1;
        @(negedge clk);
        chk("drain1", 32'(idx_out), 32'h1);
        @(negedge clk);
        chk("drain2", 32'(idx_out), 32'h7);
        @(negedge clk);
        chk("drain3", 32'(idx_out), 32'h9);
        @(negedge clk);
        chk("drain_empty", 32'(idx_vld), 32'd0);

        // id_ok low blocks acceptance
        id_ok = 1'b0;
        send(4'h1);
        @(negedge clk);
        chk("id_ok_low_vld", 32'(idx_vld), 32'd0);
        id_ok = 1'b1;

        // Reset with three entries buffered
        idx_rdy = 1'b0;
        send_keep(4'h1);
        send_keep(4'h3);
        send_keep(4'h7);
        id_code_vld = 1'b0;
        @(negedge clk);
        chk("pre_rst_vld", 32'(idx_vld), 32'd1);
        resetn = 1'b0;
        tick();
        @(negedge clk);
        chk("mid_rst_vld", 32'(idx_vld), 32'd0);
        chk("mid_rst_rdy", 32'(id_code_rdy), 32'd1);
        resetn  = 1'b1;
        idx_rdy = 1'b1;
        repeat (2) @(negedge clk);
        chk("after_rst_vld", 32'(idx_vld), 32'd0);
        chk("after_rst_rdy", 32'(id_code_rdy), 32'd1);

        // Full FIFO: pop and push offered together -> pop only
        idx_rdy = 1'b0;
        send_keep(4'h1);
        send_keep(4'h3);
        send_keep(4'h7);
        send_keep(4'hF);
        id_code_vld = 1'b0;
        @(negedge clk);
        chk("full_rdy", 32'(id_code_rdy), 32'd0);
        idx_rdy     = 1'b1;
        id_code     = 4'h0;
        id_code_vld = 1'b1;
        tick();
        idx_rdy     = 1'b0;
        id_code_vld = 1'b0;
        @(negedge clk);
        chk("full_pop_rdy", 32'(id_code_rdy), 32'd1);
        chk("full_pop_head", 32'(idx_out), 32'h1);
        idx_rdy = 1'b1;
        repeat (4) @(negedge clk);
        chk("full_pop_drained", 32'(idx_vld), 32'd0);

        // Sweep all codes with alternating downstream readiness
        for (int c = 0; c < 16; c++) begin
            idx_rdy = c[0];
            send_keep(4'(c));
        end
        id_code_vld = 1'b0;
        idx_rdy     = 1'b1;
        repeat (6) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Illegal codes 0x2 and 0xC -> separate error pulses, count 2
        @(negedge clk);
        send(4'h2);
        @(negedge clk);
        chk("err1_pulse", 32'(id_err), 32'(ERR_EN));
        chk("err1_cnt", 32'(err_cnt), ERR_EN ? 32'd1 : 32'd0);
        chk("err1_vld", 32'(idx_vld), 32'd0);
        @(negedge clk);
        chk("err1_pulse_end", 32'(id_err), 32'd0);
        send(4'hC);
        @(negedge clk);
        chk("err2_pulse", 32'(id_err), 32'(ERR_EN));
        chk("err2_cnt", 32'(err_cnt), ERR_EN ? 32'd2 : 32'd0);
        chk("err2_vld", 32'(idx_vld), 32'd0);
        @(negedge clk);
        chk("err2_pulse_end", 32'(id_err), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr_cnt", 32'(err_cnt), 32'd0);

        // Saturation, then clear racing an illegal code
        id_code     = 4'h2;
        id_code_vld = 1'b1;
        repeat (CNT_MAX + 3) tick();
        @(negedge clk);
        chk("sat_cnt", 32'(err_cnt), ERR_EN ? 32'd255 : 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr     = 1'b0;
        id_code_vld = 1'b0;
        @(negedge clk);
        chk("clr_prio_cnt", 32'(err_cnt), 32'd0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends with a summary.
    initial begin
        #100000;
        bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
